// File: rtl/ram_share_pkg.sv
// Shared types and constants for the UART-to-APB RAM FIFO arbiter.
package ram_share_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_RD_ISSUE,
    ST_RD_DONE,
    ST_BUS_RESP
  } state_e;

  localparam int unsigned APB_AW = 16;
  localparam int unsigned APB_DW = 32;

  localparam logic [7:0] REG_DATA   = 8'h00;
  localparam logic [7:0] REG_STATUS = 8'h04;
  localparam logic [7:0] REG_CTRL   = 8'h08;

  // STATUS: count occupies [AW:0]; flag bits sit at AW + offset
  localparam int unsigned STAT_EMPTY_OFS = 1;
  localparam int unsigned STAT_FULL_OFS  = 2;
  localparam int unsigned STAT_OVF_OFS   = 3;

  localparam int unsigned CTRL_FLUSH_BIT   = 0;
  localparam int unsigned CTRL_CLR_OVF_BIT = 1;

endpackage

// File: rtl/fifo_ptr_ctrl.sv
// Read/write pointers and occupancy for the RAM-backed FIFO.
module fifo_ptr_ctrl #(
  parameter int unsigned AW = 8
) (
  input  logic          clk,
  input  logic          rst_h,
  input  logic          inc_wr_i,
  input  logic          inc_rd_i,
  input  logic          flush_i,
  output logic [AW-1:0] wr_ptr_o,
  output logic [AW-1:0] rd_ptr_o,
  output logic [AW:0]   count_o,
  output logic          empty_o,
  output logic          full_o
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_wr, do_rd;

  assign empty_o  = (count_q == '0);
  assign full_o   = (count_q == (AW+1)'(DEPTH));
  assign wr_ptr_o = wr_ptr_q;
  assign rd_ptr_o = rd_ptr_q;
  assign count_o  = count_q;

  // Guards keep count inside [0, DEPTH] even on a stray strobe
  assign do_wr = inc_wr_i & ~full_o;
  assign do_rd = inc_rd_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_wr) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_rd) rd_ptr_d = rd_ptr_q + AW'(1);
      if (do_wr && !do_rd)      count_d = count_q + (AW+1)'(1);
      else if (do_rd && !do_wr) count_d = count_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst_h) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/ram_share_arbiter.sv
// Runs a single-port RAM as a FIFO: UART bytes are pushed, APB DATA reads pop.
module ram_share_arbiter
  import ram_share_pkg::*;
#(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 8
) (
  input  logic              clk,
  input  logic              rst_h,
  input  logic              wr_valid,
  input  logic [DW-1:0]     wr_data,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [APB_AW-1:0] paddr,
  input  logic [APB_DW-1:0] pwdata,
  input  logic [3:0]        pstrb,
  output logic [APB_DW-1:0] prdata,
  output logic              pready,
  output logic              pslverr,
  output logic [AW-1:0]     ram_addr,
  output logic [DW:0]       ram_din,
  output logic              ram_wrb,
  output logic              ram_rdb,
  input  logic [DW:0]       ram_dout,
  output logic [AW:0]       fifo_count,
  output logic              fifo_empty,
  output logic              fifo_full
);

  state_e              state_q, state_d;
  logic [APB_DW-1:0]   prdata_q, prdata_d;
  logic                pready_q, pready_d;
  logic                pslverr_q, pslverr_d;
  logic [AW-1:0]       ram_addr_q, ram_addr_d;
  logic [DW:0]         ram_din_q, ram_din_d;
  logic                ram_wrb_q, ram_wrb_d;
  logic                ram_rdb_q, ram_rdb_d;
  logic [DW-1:0]       hold_q, hold_d;
  logic                hold_valid_q, hold_valid_d;
  logic                ovf_q, ovf_d;

  logic                inc_wr, inc_rd, flush, consume, ovf_set, ovf_clr;
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic                write_pend;
  logic [DW-1:0]       hold_byte;
  logic                hi_ok, is_data_rd, is_status_rd, is_ctrl_wr, acc_err;
  logic [APB_DW-1:0]   status_word;
  logic                unused_bits_c;

  fifo_ptr_ctrl #(.AW(AW)) u_ptr (
    .clk      (clk),
    .rst_h    (rst_h),
    .inc_wr_i (inc_wr),
    .inc_rd_i (inc_rd),
    .flush_i  (flush),
    .wr_ptr_o (wr_ptr),
    .rd_ptr_o (rd_ptr),
    .count_o  (fifo_count),
    .empty_o  (fifo_empty),
    .full_o   (fifo_full)
  );

  assign prdata   = prdata_q;
  assign pready   = pready_q;
  assign pslverr  = pslverr_q;
  assign ram_addr = ram_addr_q;
  assign ram_din  = ram_din_q;
  assign ram_wrb  = ram_wrb_q;
  assign ram_rdb  = ram_rdb_q;

  assign unused_bits_c = ^{pstrb[3:1], pwdata[APB_DW-1:2], ram_dout[DW]};

  // A fresh strobe counts as pending so it can bypass the hold register
  assign write_pend = hold_valid_q | wr_valid;
  assign hold_byte  = hold_valid_q ? hold_q : wr_data;

  assign hi_ok        = (paddr[15:8] == 8'h00);
  assign is_data_rd   = hi_ok && (paddr[7:0] == REG_DATA)   && !pwrite;
  assign is_status_rd = hi_ok && (paddr[7:0] == REG_STATUS) && !pwrite;
  assign is_ctrl_wr   = hi_ok && (paddr[7:0] == REG_CTRL)   &&  pwrite;
  assign acc_err      = !(is_data_rd || is_status_rd || is_ctrl_wr);

  always_comb begin
    status_word                      = '0;
    status_word[AW:0]                = fifo_count;
    status_word[AW + STAT_EMPTY_OFS] = fifo_empty;
    status_word[AW + STAT_FULL_OFS]  = fifo_full;
    status_word[AW + STAT_OVF_OFS]   = ovf_q;
  end

  // Arbitration FSM; RAM-side values are set one cycle ahead of use
  always_comb begin
    state_d    = state_q;
    prdata_d   = '0;
    pready_d   = 1'b0;
    pslverr_d  = 1'b0;
    ram_addr_d = ram_addr_q;
    ram_din_d  = ram_din_q;
    ram_wrb_d  = 1'b1;
    ram_rdb_d  = 1'b1;
    inc_wr     = 1'b0;
    inc_rd     = 1'b0;
    flush      = 1'b0;
    consume    = 1'b0;
    ovf_set    = 1'b0;
    ovf_clr    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (write_pend && fifo_full) begin
          consume = 1'b1;
          ovf_set = 1'b1;
        end
        if (psel && is_data_rd && write_pend && !fifo_full) begin
          state_d    = ST_WR;
          ram_addr_d = wr_ptr;
          ram_din_d  = {1'b0, hold_byte};
          ram_wrb_d  = 1'b0;
          consume    = 1'b1;
        end else if (psel && is_data_rd && !fifo_empty) begin
          state_d    = ST_RD_ISSUE;
          ram_addr_d = rd_ptr;
          ram_rdb_d  = 1'b0;
        end else if (psel) begin
          state_d   = ST_BUS_RESP;
          pready_d  = 1'b1;
          pslverr_d = acc_err;
          if (is_status_rd) prdata_d = status_word;
          if (is_ctrl_wr && pstrb[0]) begin
            flush   = pwdata[CTRL_FLUSH_BIT];
            ovf_clr = pwdata[CTRL_CLR_OVF_BIT];
          end
        end else if (write_pend && !fifo_full) begin
          state_d    = ST_WR;
          ram_addr_d = wr_ptr;
          ram_din_d  = {1'b0, hold_byte};
          ram_wrb_d  = 1'b0;
          consume    = 1'b1;
        end
      end
      ST_WR: begin
        inc_wr  = 1'b1;
        state_d = ST_IDLE;
        if (psel && is_data_rd) begin
          state_d    = ST_RD_ISSUE;
          ram_addr_d = rd_ptr;
          ram_rdb_d  = 1'b0;
        end
      end
      ST_RD_ISSUE: begin
        inc_rd   = 1'b1;
        state_d  = ST_RD_DONE;
        pready_d = 1'b1;
        prdata_d = APB_DW'({1'b1, ram_dout[DW-1:0]});
      end
      ST_RD_DONE:  state_d = ST_IDLE;
      ST_BUS_RESP: state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // Hold register and sticky overflow; a flush discards any incoming byte
  always_comb begin
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q & ~consume;
    ovf_d        = ovf_q;
    if (wr_valid && hold_valid_q && !flush) ovf_d = 1'b1;
    if (wr_valid && !hold_valid_q && !consume) begin
      hold_valid_d = 1'b1;
      hold_d       = wr_data;
    end
    if (ovf_set) ovf_d = 1'b1;
    if (flush)   hold_valid_d = 1'b0;
    if (ovf_clr) ovf_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst_h) begin
      state_q      <= ST_IDLE;
      prdata_q     <= '0;
      pready_q     <= 1'b0;
      pslverr_q    <= 1'b0;
      ram_addr_q   <= '0;
      ram_din_q    <= '0;
      ram_wrb_q    <= 1'b1;
      ram_rdb_q    <= 1'b1;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      prdata_q     <= prdata_d;
      pready_q     <= pready_d;
      pslverr_q    <= pslverr_d;
      ram_addr_q   <= ram_addr_d;
      ram_din_q    <= ram_din_d;
      ram_wrb_q    <= ram_wrb_d;
      ram_rdb_q    <= ram_rdb_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      ovf_q        <= ovf_d;
    end
  end

endmodule

// File: doc/ram_share_arbiter.md
RAM_SHARE_ARBITER -- requirements
Module: ram_share_arbiter

Interface
REQ-001 Parameter AW, 8, RAM address width; depth is 2**AW.
REQ-002 Parameter DW, 8, payload width; RAM word width is DW+1, and bit DW is written 0.
REQ-003 Clocking and reset SHALL be one clock, clk, with reset rst_h synchronous and active-high.
REQ-004 Ports SHALL be, in order:
- clk, in, 1: system clock; the RAM is clocked on ~clk outside this block.
- rst_h, in, 1: synchronous active-high reset.
- wr_valid, in, 1: one-cycle write-request strobe from the UART receiver.
- wr_data, in, DW: byte qualified by wr_valid.
- psel / penable / pwrite, in, 1 each: APB control.
- paddr, in, 16: APB address.
- pwdata, in, 32: APB write data.
- pstrb, in, 4: APB write strobes.
- prdata, out, 32: APB read data.
- pready, out, 1: APB ready.
- pslverr, out, 1: APB error.
- ram_addr, out, AW: shared read/write address.
- ram_din, out, DW+1: RAM write data.
- ram_wrb, out, 1: RAM write enable, active-low.
- ram_rdb, out, 1: RAM read enable, active-low.
- ram_dout, in, DW+1: RAM read data.
- fifo_count, out, AW+1: occupancy.
- fifo_empty, out, 1: occupancy is 0.
- fifo_full, out, 1: occupancy is 2**AW.

Function
REQ-005 The block SHALL run the single-address RAM as a FIFO, with UART bytes as writes and APB DATA reads as pops; at most one RAM access is issued per clk.
REQ-006 All RAM-side outputs SHALL be registered; the RAM samples them on the following falling edge, and ram_dout SHALL be sampled on the next rising edge.
REQ-007 A wr_valid SHALL load a 1-entry hold register; if the hold register is already occupied, the new byte is dropped and sticky overflow is set.
REQ-008 The FSM SHALL have states IDLE, WR, RD_ISSUE, RD_DONE, BUS_RESP.
REQ-009 In IDLE, a pending hold byte SHALL take priority over a pending APB DATA read.
REQ-010 The WR state SHALL last one cycle and drive ram_addr=wr_ptr, ram_din={0,hold}, ram_wrb=0; it increments wr_ptr and count, clears the hold register, and returns to IDLE.
REQ-011 A hold byte present while full SHALL be discarded without a RAM access, and sticky overflow is set.
REQ-012 Register map on paddr[7:0], with paddr[15:8] required to be 0:
- 0x00 DATA: RO, pop.
- 0x04 STATUS: RO.
- 0x08 CTRL: WO.
REQ-013 A DATA read on a non-empty FIFO SHALL take this sequence:
- RD_ISSUE drives ram_addr=rd_ptr, ram_rdb=0 for one cycle, and increments rd_ptr and decrements count.
- RD_DONE latches prdata={23'b0,1'b1,ram_dout[DW-1:0]} and asserts pready.
REQ-014 A DATA read whose setup phase is at cycle S SHALL see pready=1 in cycle S+2 when no write is pending, and in S+3 when a write is serviced first.
REQ-015 A DATA read on an empty FIFO SHALL complete with pready=1 in cycle S+1 and prdata=0 (bit 8 = 0 marks no data), with no pointer change.
REQ-016 A STATUS read SHALL complete with pready=1 in S+1 and prdata fields:
- [AW:0] count.
- [AW+1] empty.
- [AW+2] full.
- [AW+3] overflow.
- all other bits 0.
REQ-017 A CTRL write SHALL complete in S+1; when pstrb[0]=1, pwdata[0]=1 flushes (pointers, count and hold register to 0) and pwdata[1]=1 clears overflow.
REQ-018 These accesses SHALL complete in S+1 with pslverr=1 and no state change:
- unmapped address;
- write to DATA or STATUS;
- read of CTRL.
REQ-019 pready and pslverr SHALL each be high for exactly one cycle per transfer, coincident with penable=1.
REQ-020 prdata SHALL return to 0 after the completing cycle.
REQ-021 A flush SHALL win over a wr_valid in the same cycle, and that byte is discarded.
REQ-022 Pointers SHALL wrap from 2**AW-1 to 0.
REQ-023 Count SHALL never exceed 2**AW or go below 0.
REQ-024 fifo_empty and fifo_full SHALL be combinational decodes of count.
REQ-025 Idle RAM outputs SHALL be ram_wrb=1 and ram_rdb=1, with ram_addr and ram_din held.

Reset
REQ-026 While rst_h=1 at a rising edge, the block SHALL load:
- state=IDLE;
- wr_ptr, rd_ptr, count = 0;
- hold register empty, overflow=0;
- prdata=0, pready=0, pslverr=0;
- ram_addr=0, ram_din=0, ram_wrb=1, ram_rdb=1.
REQ-027 Reset asserted mid-transfer SHALL abort the transfer with no pready; the master must restart the transfer.

Structure
REQ-028 Package ram_share_pkg SHALL hold:
- the FSM state enum;
- register offsets 0x00/0x04/0x08;
- STATUS bit positions;
- CTRL bit positions.
REQ-029 One sub-module, fifo_ptr_ctrl, SHALL own wr_ptr, rd_ptr, count, empty and full, driven by inc_wr/inc_rd/flush strobes.
REQ-030 Target size SHALL be about 200 lines of RTL.

Verification
REQ-031 The bench SHALL cover these directed scenarios:
- Write 0xA5 then 0x3C via wr_valid, then two DATA reads -> prdata 0x1A5 then 0x13C, pready in S+2, count back to 0, empty=1.
- DATA read when empty -> pready in S+1, prdata=0x000, pslverr=0, pointers unchanged.
- 256 writes then one more -> full=1, count=256, overflow=1; 256 reads return data in order, and pointers wrap to 0.
- wr_valid arrives in the same cycle as a DATA setup phase -> WR serviced first, pready in S+3, correct data returned.
- CTRL write 0x3 with pstrb=0x1 when count=5 and overflow=1 -> STATUS read gives count 0, empty=1, overflow=0.
- Read paddr 0x0C, and write to 0x04 -> pready and pslverr both high in S+1, and STATUS unchanged.
